shift_count_timer: RTL

SHIFT_COUNT_TIMER -- requirements
Module: shift_count_timer

---
 rtl/shift_count_timer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/shift_count_timer.sv
// -----------------------------------------------------------------------------
// shift_count_timer
//
// Purpose:
//   Serially loads a WIDTH-bit count value (MSB first) after a start pulse.
//   It then counts that value down to zero, taking one step every TICKS
//   clock cycles. When a step occurs with the value already at zero, the
//   block raises done and holds it until ack is seen.
//
// Ports:
//   clk       - sole clock, all state changes on its rising edge
//   reset     - synchronous, active-high reset
//   start     - begin a serial load (only looked at while idle)
//   data_in   - serial count value, MSB first
//   ack       - acknowledge of done (only looked at while done)
//   count_out - value register: remaining steps
//   counting  - high while the countdown is running
//   done      - high while waiting for ack after the countdown
// -----------------------------------------------------------------------------
module shift_count_timer #(
    parameter int WIDTH = 4,
    parameter int TICKS = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             data_in,
    input  logic             ack,
    output logic [WIDTH-1:0] count_out,
    output logic             counting,
    output logic             done
);

    // The prescaler must hold 0..TICKS-1. It is kept at least one bit wide
    // so that TICKS=1 still gives a legal vector. In that case the prescaler
    // always sits at its terminal value, and every COUNT cycle is a step.
    localparam int PW = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam int BW = $clog2(WIDTH);
    localparam logic [PW-1:0] LAST_TICK = PW'(TICKS - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COUNT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] value;
    logic [PW-1:0]    prescaler;
    logic [BW-1:0]    bit_cnt;
    logic             step;
    logic             last_bit;

    assign count_out = value;

    // State register; reset wins over every transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. counting and done are decoded from the state only,
    // so no input reaches them combinationally.
    always_comb begin
        state_next = state;
        step       = (state == COUNT) && (prescaler == LAST_TICK);
        last_bit   = (bit_cnt == LAST_BIT);
        counting   = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (last_bit) begin
                    state_next = COUNT;
                end
            end
            COUNT: begin
                counting = 1'b1;
                if (step && (value == '0)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers. The prescaler is cleared on every LOAD cycle, so
    // it is already zero on the first COUNT cycle. A step with value zero
    // only moves the FSM to DONE; the value stays at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            value     <= '0;
            prescaler <= '0;
            bit_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                end
                LOAD: begin
                    value     <= {value[WIDTH-2:0], data_in};
                    bit_cnt   <= bit_cnt + 1'b1;
                    prescaler <= '0;
                end
                COUNT: begin
                    if (step) begin
                        prescaler <= '0;
                        if (value != '0) begin
                            value <= value - 1'b1;
                        end
                    end else begin
                        prescaler <= prescaler + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
